// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields (opcode, registers, funct3/7,
// signed immediate) into 32-bit instruction words and streams them into
// instruction memory at consecutive word addresses. A start/done FSM
// brackets each program load; input and output sides are valid/ready.
//
// Handshake semantics (both sides): a transfer happens on a rising clock
// edge where valid && ready are both high. A producer holding valid keeps
// its payload stable until that edge; ready may depend combinationally on
// the consumer's own state, but valid never depends on ready.
module instr_encoder #(
  parameter int unsigned         WIDTH     = 32,
  parameter int unsigned         ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [WIDTH-1:0]  in_imm,
  input  logic              in_last,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       wr_count,
  output logic [1:0]        state_dbg
);

  // Load sequencing states; exported on state_dbg for observation.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Supported major opcodes.
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STYPE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BTYPE = 7'b1100011;

  // Immediate ranges representable by the 12-bit and 13-bit (branch) fields.
  localparam logic signed [WIDTH-1:0] IMM12_MIN = WIDTH'(-2048);
  localparam logic signed [WIDTH-1:0] IMM12_MAX = WIDTH'(2047);
  localparam logic signed [WIDTH-1:0] IMMB_MIN  = WIDTH'(-4096);
  localparam logic signed [WIDTH-1:0] IMMB_MAX  = WIDTH'(4094);

  state_t state, state_next;

  logic                    accept;
  logic                    wr_fire;
  logic                    start_go;
  logic signed [WIDTH-1:0] imm_s;
  logic                    imm_fits12;
  logic                    imm_fits_b;
  logic [31:0]             enc_word;
  logic                    enc_legal;

  assign imm_s    = in_imm;
  assign accept   = in_valid && in_ready;
  assign wr_fire  = wr_valid && wr_ready;
  assign start_go = (state == S_IDLE) && start;

  // Range checks on the full-width signed immediate (upper bits matter:
  // a value that only fits after truncation is out of range).
  assign imm_fits12 = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
  assign imm_fits_b = (imm_s >= IMMB_MIN) && (imm_s <= IMMB_MAX) && !in_imm[0];

  // Field packing and legality per opcode format.
  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b0;
    case (in_opcode)
      OP_ITYPE, OP_LOAD: begin
        enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_legal = imm_fits12;
      end
      OP_STYPE: begin
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_legal = imm_fits12;
      end
      OP_RTYPE: begin
        enc_word  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_legal = 1'b1;
      end
      OP_BTYPE: begin
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_legal = imm_fits_b;
      end
      default: begin
        enc_word  = 32'd0;
        enc_legal = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        // The final bundle ends input acceptance even if it was dropped.
        if (accept && in_last) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        // Leave once the output register is empty or empties this cycle.
        if (!wr_valid || wr_ready) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // FSM outputs: input-side ready and status flags.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    state_dbg = state;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_RUN: begin
        // Room exists when the output register is empty or draining now.
        in_ready = !wr_valid || wr_ready;
      end
      S_FLUSH: begin
        in_ready = 1'b0;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Output register: a legal accept loads a new word; a drain with no
  // replacement empties it. Drain and load in one cycle keep it full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_valid <= 1'b0;
      wr_data  <= '0;
    end else if (accept && enc_legal) begin
      wr_valid <= 1'b1;
      wr_data  <= WIDTH'(enc_word);
    end else if (wr_fire) begin
      wr_valid <= 1'b0;
    end
  end

  // Write address and count track completed writes only, so the address
  // shown with a word is the one it is written to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr  <= BASE_ADDR;
      wr_count <= 16'd0;
    end else if (start_go) begin
      wr_addr  <= BASE_ADDR;
      wr_count <= 16'd0;
    end else if (wr_fire) begin
      wr_addr  <= wr_addr + ADDR_W'(4);
      wr_count <= wr_count + 16'd1;
    end
  end

  // Sticky error flag: set by any dropped bundle, cleared at load start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (start_go) begin
      err <= 1'b0;
    end else if (accept && !enc_legal) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed cases for each format, back-pressure,
// illegal bundles and reset mid-load, followed by a randomized load with
// random write back-pressure. Expected words come from an arithmetic model.
module tb_instr_encoder;

  localparam int          WIDTH  = 32;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [6:0]        in_opcode = '0;
  logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]        in_funct3 = '0;
  logic [6:0]        in_funct7 = '0;
  logic [WIDTH-1:0]  in_imm = '0;
  logic              in_last = 1'b0;
  logic              wr_valid;
  logic              wr_ready = 1'b1;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              busy, done, err;
  logic [15:0]       wr_count;
  logic [1:0]        state_dbg;

  instr_encoder #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .wr_count(wr_count), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_imm_q[$];
  bit          exp_rt_q[$];
  int          m_count;
  bit          m_err;
  bit          rnd_on;
  int          bnd[10] = '{-2049, -2048, 2047, 2048, -4096, -4097, 4094, 4095, 4096, -4098};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_legal(int unsigned op, int imm);
    case (op)
      32'h13, 32'h03, 32'h23: return (imm >= -2048) && (imm <= 2047);
      32'h63:                 return (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
      32'h33:                 return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Builds the word by weighting each field with its bit position.
  function automatic logic [31:0] model_word(int unsigned op, int unsigned rd, int unsigned rs1,
                                             int unsigned rs2, int unsigned f3, int unsigned f7,
                                             int imm);
    int unsigned u;
    int unsigned w;
    u = unsigned'(imm);
    w = op + f3 * 4096 + rs1 * 32768;
    case (op)
      32'h13, 32'h03: w = w + rd * 128 + (u % 4096) * 1048576;
      32'h23: w = w + rs2 * 1048576 + (u % 32) * 128 + ((u / 32) % 128) * 33554432;
      32'h33: w = w + rd * 128 + rs2 * 1048576 + f7 * 33554432;
      32'h63: w = w + rs2 * 1048576 + ((u / 2) % 16) * 256 + ((u / 2048) % 2) * 128
                + ((u / 32) % 64) * 33554432 + ((u / 4096) % 2) * 32'h8000_0000;
      default: w = 0;
    endcase
    return w;
  endfunction

  // Immediate decoder for I/LOAD and S words.
  function automatic logic [31:0] dec_imm(logic [31:0] w);
    int s;
    s = signed'(w);
    if (w[6:0] == 7'h23) return ((s >>> 25) * 32) + int'((w >> 7) & 32'h1F);
    return s >>> 20;
  endfunction

  // ---------------- monitor ----------------
  logic [31:0] prev_addr, prev_data, pa, pd, pi;
  bit          prev_stall = 1'b0;
  bit          prt;

  // Checks every completed write against the queue plus hold/ready rules.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(wr_valid), 32'd1);
        chk("hold_addr", wr_addr, prev_addr);
        chk("hold_data", wr_data, prev_data);
      end
      if (wr_valid && !wr_ready) chk("in_ready_when_full", 32'(in_ready), 32'd0);
      if (wr_valid && wr_ready) begin
        checks++;
        if (exp_data_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected", wr_addr, wr_data);
        end else begin
          pa = exp_addr_q.pop_front();
          pd = exp_data_q.pop_front();
          pi = exp_imm_q.pop_front();
          prt = exp_rt_q.pop_front();
          chk("wr_addr", wr_addr, pa);
          chk("wr_data", wr_data, pd);
          if (prt) chk("imm_roundtrip", dec_imm(wr_data), pi);
        end
      end
      prev_stall = wr_valid && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_count = 0;
    m_err = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_err_clear", 32'(err), 32'd0);
    chk("start_count_clear", 32'(wr_count), 32'd0);
    chk("start_addr", wr_addr, BASE);
  endtask

  task automatic send(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                      logic [2:0] f3, logic [6:0] f7, int imm, bit last,
                      bit use_fix, logic [31:0] fix_word);
    bit legal;
    int n;
    legal = model_legal(32'(op), imm);
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
        in_valid = 1'b0;
        return;
      end
    end
    if (legal) begin
      exp_addr_q.push_back(BASE + 32'(m_count * 4));
      exp_data_q.push_back(use_fix ? fix_word
                           : model_word(32'(op), 32'(rd), 32'(rs1), 32'(rs2), 32'(f3), 32'(f7), imm));
      exp_imm_q.push_back(imm);
      exp_rt_q.push_back(op == 7'h13 || op == 7'h03 || op == 7'h23);
      m_count++;
    end else begin
      m_err = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    if (legal) chk("latency_wr_valid", 32'(wr_valid), 32'd1);
    else chk("err_set", 32'(err), 32'd1);
  endtask

  task automatic wait_done();
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (n < 300 && !seen) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      n++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("done_count", 32'(wr_count), 32'(m_count));
      chk("done_err", 32'(err), 32'(m_err));
      chk("done_busy", 32'(busy), 32'd1);
      chk("queue_drained", 32'(exp_data_q.size()), 32'd0);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
    chk({tag, "_wr_addr"}, wr_addr, BASE);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_wr_count"}, 32'(wr_count), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [6:0] op;
    int         imm;
    int unsigned sel;

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // ITYPE: addi x1, x2, -1
    do_start();
    send(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, -1, 1'b1, 1'b1, 32'hFFF10093);
    wait_done();

    // STYPE: sw x5, -4(x2)
    do_start();
    send(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, -4, 1'b1, 1'b1, 32'hFE512E23);
    wait_done();

    // Back-pressure: three bundles while imem stalls for 5 cycles
    do_start();
    wr_ready = 1'b0;
    fork
      begin
        send(7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 10, 1'b0, 1'b0, 32'd0);
        send(7'h33, 5'd6, 5'd7, 5'd8, 3'd0, 7'h20, 0, 1'b0, 1'b0, 32'd0);
        send(7'h03, 5'd9, 5'd10, 5'd0, 3'd2, 7'd0, -100, 1'b1, 1'b0, 32'd0);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        wr_ready = 1'b1;
      end
    join
    wait_done();

    // Illegal bundles mid-stream; addresses stay contiguous
    do_start();
    send(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 2047, 1'b0, 1'b0, 32'd0);
    send(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 2048, 1'b0, 1'b0, 32'd0);
    send(7'h7F, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 0, 1'b0, 1'b0, 32'd0);
    chk("err_sticky", 32'(err), 32'd1);
    send(7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, -2048, 1'b1, 1'b0, 32'd0);
    wait_done();

    // BTYPE: bne x1, x2, -8 then an odd offset
    do_start();
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, -8, 1'b0, 1'b1, 32'hFE209CE3);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 3, 1'b1, 1'b0, 32'd0);
    wait_done();

    // Randomized load with random write back-pressure
    do_start();
    rnd_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          sel = $urandom_range(0, 9);
          if (sel < 2)      op = 7'h13;
          else if (sel < 3) op = 7'h03;
          else if (sel < 5) op = 7'h23;
          else if (sel < 7) op = 7'h33;
          else if (sel < 9) op = 7'h63;
          else              op = 7'($urandom_range(0, 127));
          case ($urandom_range(0, 3))
            0:       imm = int'($urandom_range(0, 4095)) - 2048;
            1:       imm = bnd[$urandom_range(0, 9)];
            2:       imm = signed'($urandom());
            default: imm = 2 * (int'($urandom_range(0, 4095)) - 2048);
          endcase
          send(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), imm, k == 39, 1'b0, 32'd0);
        end
        wait_done();
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          wr_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    wr_ready = 1'b1;

    // Async reset while FLUSH holds an unwritten word
    do_start();
    wr_ready = 1'b0;
    send(7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 77, 1'b1, 1'b0, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_imm_q.delete();
    exp_rt_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    wr_ready = 1'b1;
    @(posedge clk); #1;
    do_start();
    send(7'h13, 5'd7, 5'd8, 5'd0, 3'd4, 7'd0, 300, 1'b1, 1'b0, 32'd0);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute bound on simulation time.
  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
